pwm_fade_array: RTL and testbench

- Multi-channel, parametrised successor to the single-LED PWM fader.
- Drives CHANNELS independent PWM outputs from one shared period counter.
- Each channel runs its own fade engine, configured at runtime through a write port.
- Sits between the board control logic and the LED/driver pins.

---
 rtl/pwm_fade_array.sv | 164 ++++++++++++++++
 tb/tb_pwm_fade_array.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_fade_array: CHANNELS PWM outputs on one shared period counter, each    |
// | with its own runtime-configured fade engine. PWM_PHASE_EN staggers phases. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwm_fade_array #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TICK_DIV = 256
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [WIDTH-1:0]                           period,
  input  logic                                       enable,
  input  logic                                       cfg_we,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                 cfg_mode,
  input  logic [WIDTH-1:0]                           cfg_min,
  input  logic [WIDTH-1:0]                           cfg_max,
  output logic [CHANNELS-1:0]                        pwm_out,
  output logic [CHANNELS*WIDTH-1:0]                  duty_mon,
  output logic                                       wrap
);

  localparam int unsigned     c_tdiv_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_tdiv_w-1:0] c_tdiv_last = c_tdiv_w'(TICK_DIV - 1);
  localparam logic [1:0]      c_mode_hold = 2'd0;
  localparam logic [1:0]      c_mode_tri  = 2'd1;
  localparam logic [1:0]      c_mode_saw  = 2'd2;
  localparam logic [1:0]      c_mode_off  = 2'd3;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic [c_tdiv_w-1:0] tdiv_q, tdiv_d;
  logic                w_run, w_at_end, w_tick;

  assign w_run    = (period != '0);
  assign w_at_end = w_run && (cnt_q >= period - WIDTH'(1));
  assign w_tick   = enable && (tdiv_q == c_tdiv_last);

  always_comb begin : p_counters
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    tdiv_d = tdiv_q;
    if (!w_run) begin
      cnt_d = '0;
    end else if (w_at_end) begin
      cnt_d  = '0;
      wrap_d = 1'b1;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
    if (enable) begin
      tdiv_d = w_tick ? '0 : tdiv_q + c_tdiv_w'(1);
    end
  end

  always_ff @(posedge clk) begin : p_counters_ff
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      tdiv_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      tdiv_q <= tdiv_d;
    end
  end

  assign wrap = wrap_q;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] duty_q, duty_d, active_q, active_d;
      logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
      logic [1:0]       mode_q, mode_d;
      logic             dir_q, dir_d;   // 1 = fading down
      logic             pwm_q, pwm_d;
      logic             w_sel;
      logic [WIDTH-1:0] w_emax, w_pcnt;

`ifdef PWM_PHASE_EN
      localparam int unsigned c_log2_ch = $clog2(CHANNELS);
      logic [WIDTH:0] w_off, w_sum;
      assign w_off  = (WIDTH+1)'((period >> c_log2_ch) * WIDTH'(i));
      assign w_sum  = {1'b0, cnt_q} + w_off;
      assign w_pcnt = (w_sum >= {1'b0, period}) ? WIDTH'(w_sum - {1'b0, period})
                                                : WIDTH'(w_sum);
`else
      assign w_pcnt = cnt_q;
`endif

      assign w_sel  = cfg_we && (32'(cfg_ch) == i);
      assign w_emax = (max_q > min_q) ? max_q : min_q;

      always_comb begin : p_fade
        duty_d   = duty_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        min_d    = min_q;
        max_d    = max_q;
        active_d = w_at_end ? duty_q : active_q;
        pwm_d    = w_run && (w_pcnt < active_q);
        // A write to this channel takes priority over a coincident fade step
        if (w_sel) begin
          mode_d = cfg_mode;
          min_d  = cfg_min;
          max_d  = cfg_max;
          dir_d  = 1'b0;
          duty_d = (cfg_mode == c_mode_off) ? '0 : cfg_min;
        end else if (w_tick) begin
          case (mode_q)
            c_mode_hold: duty_d = min_q;
            c_mode_tri: begin
              if (!dir_q) begin
                if (({1'b0, duty_q} + (WIDTH+1)'(1)) >= {1'b0, w_emax}) begin
                  duty_d = w_emax;
                  dir_d  = 1'b1;
                end else begin
                  duty_d = duty_q + WIDTH'(1);
                end
              end else begin
                if ({1'b0, duty_q} <= ({1'b0, min_q} + (WIDTH+1)'(1))) begin
                  duty_d = min_q;
                  dir_d  = 1'b0;
                end else begin
                  duty_d = duty_q - WIDTH'(1);
                end
              end
            end
            c_mode_saw: duty_d = (duty_q >= w_emax) ? min_q : duty_q + WIDTH'(1);
            default:    duty_d = '0;
          endcase
        end
      end

      always_ff @(posedge clk) begin : p_fade_ff
        if (rst) begin
          duty_q   <= '0;
          active_q <= '0;
          min_q    <= '0;
          max_q    <= '0;
          mode_q   <= c_mode_hold;
          dir_q    <= 1'b0;
          pwm_q    <= 1'b0;
        end else begin
          duty_q   <= duty_d;
          active_q <= active_d;
          min_q    <= min_d;
          max_q    <= max_d;
          mode_q   <= mode_d;
          dir_q    <= dir_d;
          pwm_q    <= pwm_d;
        end
      end

      assign pwm_out[i]                 = pwm_q;
      assign duty_mon[i*WIDTH +: WIDTH] = active_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_array.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for pwm_fade_array: cycle model compared every cycle plus directed literal checks.
module tb_pwm_fade_array;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int TD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  period = 8'd10;
  logic          enable = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = 2'd0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [W-1:0]  cfg_min = '0;
  logic [W-1:0]  cfg_max = '0;
  logic [CH-1:0] pwm_out;
  logic [CH*W-1:0] duty_mon;
  logic          wrap;

  pwm_fade_array #(.CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .period(period), .enable(enable),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_min(cfg_min), .cfg_max(cfg_max),
    .pwm_out(pwm_out), .duty_mon(duty_mon), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model, integer arithmetic
  int m_cnt, m_tdiv, m_wrap;
  int m_duty[CH], m_act[CH], m_mode[CH], m_lo[CH], m_hi[CH], m_step[CH], m_pwm[CH];
  bit m_valid = 0;
  int trace_ch = 0;
  int q_trace[$];

  function automatic int phase_cnt(input int c, input int p, input int ch);
`ifdef PWM_PHASE_EN
    return (c + ch * (p / CH)) % p;
`else
    return c + 0 * (p + ch);
`endif
  endfunction

  always @(posedge clk) begin : model
    int p, top;
    bit at_end, tk;
    if (rst) begin
      m_cnt = 0; m_tdiv = 0; m_wrap = 0; m_valid = 1;
      for (int c = 0; c < CH; c++) begin
        m_duty[c] = 0; m_act[c] = 0; m_mode[c] = 0; m_lo[c] = 0; m_hi[c] = 0;
        m_step[c] = 1; m_pwm[c] = 0;
      end
    end else begin
      p      = int'(period);
      at_end = (p != 0) && (m_cnt >= p - 1);
      tk     = enable && (m_tdiv == TD - 1);
      for (int c = 0; c < CH; c++) begin
        m_pwm[c] = (p != 0 && phase_cnt(m_cnt, p, c) < m_act[c]) ? 1 : 0;
        if (at_end) m_act[c] = m_duty[c];
        top = (m_hi[c] > m_lo[c]) ? m_hi[c] : m_lo[c];
        if (cfg_we && int'(cfg_ch) == c) begin
          m_mode[c] = int'(cfg_mode); m_lo[c] = int'(cfg_min); m_hi[c] = int'(cfg_max);
          m_step[c] = 1;
          m_duty[c] = (cfg_mode == 2'd3) ? 0 : int'(cfg_min);
        end else if (tk) begin
          case (m_mode[c])
            0: m_duty[c] = m_lo[c];
            1: begin
              m_duty[c] += m_step[c];
              if (m_step[c] > 0 && m_duty[c] >= top) begin
                m_duty[c] = top; m_step[c] = -1;
              end else if (m_step[c] < 0 && m_duty[c] <= m_lo[c]) begin
                m_duty[c] = m_lo[c]; m_step[c] = 1;
              end
            end
            2: m_duty[c] = (m_duty[c] >= top) ? m_lo[c] : m_duty[c] + 1;
            default: m_duty[c] = 0;
          endcase
          if (c == trace_ch) q_trace.push_back(m_duty[c]);
        end
      end
      m_wrap = at_end ? 1 : 0;
      m_cnt  = (p == 0 || at_end) ? 0 : m_cnt + 1;
      if (enable) m_tdiv = tk ? 0 : m_tdiv + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [CH-1:0]   ep;
    logic [CH*W-1:0] em;
    if (m_valid) begin
      for (int c = 0; c < CH; c++) begin
        ep[c] = m_pwm[c][0];
        em[c*W +: W] = m_act[c][W-1:0];
      end
      check("cyc_pwm", pwm_out, ep);
      check("cyc_mon", duty_mon, em);
      check("cyc_wrap", wrap, m_wrap[0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int mode, input int lo, input int hi);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_min = W'(lo); cfg_max = W'(hi);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_wrap(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (wrap !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (wrap !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no wrap within 100 cycles", name);
    end
  endtask

  function automatic int model_duty(input int c);
    return m_duty[c];
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k, hi_cnt, viol, toggles, prev0;
    int exp_tri[5], exp_saw[5], rise[CH], exp_off[CH];
    logic [9:0] patt;
    logic [CH*W-1:0] prev_mon, snap;
    logic [CH-1:0] prev_pwm;

    // Reset
    cyc(3);
    check("rst_pwm", pwm_out, 0);
    check("rst_wrap", wrap, 0);
    check("rst_mon", duty_mon, 0);
    rst = 1'b0;
    wait_wrap("first_wrap");
    k = 0;
    do begin @(negedge clk); k++; end while (wrap !== 1'b1 && k < 50);
    check("wrap_interval", k, 10);

    // Static duty
    cfg(0, 0, 3, 0);
    wait_wrap("static3");
    for (int j = 1; j <= 10; j++) begin @(negedge clk); patt[j-1] = pwm_out[0]; end
    check("static3_pattern", patt, 10'b0000000111);
    cfg(0, 0, 0, 0);
    wait_wrap("static0_a"); wait_wrap("static0_b");
    hi_cnt = 0;
    for (int j = 0; j < 10; j++) begin @(negedge clk); hi_cnt += pwm_out[0]; end
    check("static0_highs", hi_cnt, 0);
    cfg(0, 0, 12, 0);
    wait_wrap("static12_a"); wait_wrap("static12_b");
    hi_cnt = 0;
    for (int j = 0; j < 10; j++) begin @(negedge clk); hi_cnt += pwm_out[0]; end
    check("static12_highs", hi_cnt, 10);

    // Triangle
    period = 8'd4;
    trace_ch = 1;
    cfg(1, 1, 1, 3);
    q_trace.delete();
    check("tri_start", model_duty(1), 1);
    exp_tri = '{2, 3, 2, 1, 2};
    viol = 0;
    prev_mon = duty_mon;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (duty_mon !== prev_mon && wrap !== 1'b1) viol++;
      prev_mon = duty_mon;
    end
    check("mon_only_at_wrap", viol, 0);
    for (int n = 0; n < 5; n++)
      check($sformatf("tri_seq%0d", n), (n < q_trace.size()) ? q_trace[n] : -1, exp_tri[n]);

    // Saw, then inverted bounds
    trace_ch = 2;
    cfg(2, 2, 2, 4);
    q_trace.delete();
    check("saw_start", model_duty(2), 2);
    cyc(20);
    exp_saw = '{3, 4, 2, 3, 4};
    for (int n = 0; n < 5; n++)
      check($sformatf("saw_seq%0d", n), (n < q_trace.size()) ? q_trace[n] : -1, exp_saw[n]);
    cfg(2, 1, 5, 3);
    cyc(12);
    check("inv_model", model_duty(2), 5);
    wait_wrap("inv_a"); wait_wrap("inv_b");
    check("inv_mon", duty_mon[2*W +: W], 5);

    // Collision of config write with a tick
    cfg(0, 2, 0, 200);
    cfg(3, 0, 5, 5);
    k = 0;
    @(negedge clk);
    while (m_tdiv != TD - 1 && k < 10) begin @(negedge clk); k++; end
    check("tick_found", m_tdiv, TD - 1);
    prev0 = model_duty(0);
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'd1; cfg_min = 8'd7; cfg_max = 8'd9;
    @(negedge clk);
    cfg_we = 1'b0;
    check("collide_ch1", model_duty(1), 7);
    check("collide_ch0", model_duty(0), (prev0 >= 200) ? 0 : prev0 + 1);
    cyc(8);

    // Freeze
    period = 8'd10;
    enable = 1'b0;
    wait_wrap("freeze_a"); wait_wrap("freeze_b");
    for (int c = 0; c < CH; c++) snap[c*W +: W] = m_act[c][W-1:0];
    toggles = 0;
    prev_pwm = pwm_out;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      toggles += (pwm_out != prev_pwm) ? 1 : 0;
      prev_pwm = pwm_out;
    end
    check("freeze_mon", duty_mon, snap);
    check("freeze_toggles", (toggles > 0) ? 1 : 0, 1);
    enable = 1'b1;

    // Period zero
    period = 8'd0;
    cyc(3);
    viol = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (pwm_out !== '0 || wrap !== 1'b0) viol++;
    end
    check("period0_low", viol, 0);

    // Reset mid-operation
    period = 8'd10;
    cyc(17);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pwm", pwm_out, 0);
    check("midrst_mon", duty_mon, 0);
    check("midrst_wrap", wrap, 0);
    rst = 1'b0;

    // Phase relationship
    period = 8'd8;
    for (int c = 0; c < CH; c++) cfg(c, 0, 2, 2);
    wait_wrap("phase_a"); wait_wrap("phase_b");
`ifdef PWM_PHASE_EN
    exp_off = '{0, 6, 4, 2};
`else
    exp_off = '{0, 0, 0, 0};
`endif
    for (int c = 0; c < CH; c++) rise[c] = -1;
    prev_pwm = pwm_out;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++)
        if (rise[c] < 0 && pwm_out[c] && !prev_pwm[c]) rise[c] = j;
      prev_pwm = pwm_out;
    end
    for (int c = 0; c < CH; c++)
      check($sformatf("phase_off%0d", c),
            (rise[c] < 0 || rise[0] < 0) ? -1 : (rise[c] - rise[0] + 8) % 8, exp_off[c]);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
